// File: rtl/icache_sa.sv
// Set-associative instruction cache with round-robin replacement, deferred fence.i flush
// and AXI4 burst refill. Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_sa #(
    parameter int WAYS       = 2,
    parameter int SETS       = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inst_require,
    input  logic [31:0] pc,
    input  logic        fencei,
    input  logic        ctrl_valid,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic        inst_err,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int OFF = $clog2(LINE_WORDS);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = 30 - OFF - IDX;
    localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BW  = OFF + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_ADDR,
        S_REFILL,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [29:0]     pc_q;
    logic [WAYS-1:0] valid_q [SETS];
    logic [TAG-1:0]  tag_q   [WAYS][SETS];
    logic [31:0]     data_q  [WAYS][SETS][LINE_WORDS];
    logic [WW-1:0]   ptr_q   [SETS];
    logic [WW-1:0]   victim_q;
    logic [BW-1:0]   beat_q;
    logic            err_q;
    logic            flush_pending_q;
    logic [31:0]     cap_q;

    logic [OFF-1:0]  off;
    logic [IDX-1:0]  idx;
    logic [TAG-1:0]  tag;
    logic            hit;
    logic [WW-1:0]   hit_way;
    logic [WW-1:0]   victim;
    logic            found_inv;
    logic [31:0]     hit_word;
    logic            flush_req;
    logic            do_flush;
    logic            beat_fire;
    logic            beat_in_line;
    logic [BW-1:0]   beat_cnt_next;
    logic            err_next;
    logic            commit;
    logic [WW-1:0]   ptr_inc;
    logic            unused_pc;

    assign unused_pc = ^pc[1:0];

    assign off = pc_q[OFF-1:0];
    assign idx = pc_q[OFF+IDX-1:OFF];
    assign tag = pc_q[29:OFF+IDX];

    // Tag match picks the hit way; the lowest invalid way is preferred as victim over the pointer.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        found_inv = 1'b0;
        victim    = ptr_q[idx];
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[w][idx] == tag) && !hit) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid_q[idx][w] && !found_inv) begin
                found_inv = 1'b1;
                victim    = WW'(w);
            end
        end
    end

    assign hit_word = data_q[hit_way][idx][off];

    assign flush_req     = ctrl_valid & fencei;
    assign do_flush      = (state_q == S_IDLE) && (flush_req || flush_pending_q);
    assign beat_fire     = (state_q == S_REFILL) && rvalid;
    assign beat_in_line  = (beat_q < BW'(LINE_WORDS));
    assign beat_cnt_next = beat_in_line ? (beat_q + BW'(1)) : beat_q;
    assign err_next      = err_q | (rresp != 2'b00);
    // A line is only installed when every word arrived cleanly.
    assign commit        = beat_fire && rlast && (beat_cnt_next == BW'(LINE_WORDS)) && !err_next;
    assign ptr_inc       = (WAYS == 1) ? '0 : (ptr_q[idx] + WW'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!do_flush && inst_require) state_d = S_LOOKUP;
            S_LOOKUP: state_d = hit ? S_IDLE : S_ADDR;
            S_ADDR:   if (arready) state_d = S_REFILL;
            S_REFILL: if (rvalid && rlast) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        arvalid = (state_q == S_ADDR);
        araddr  = {pc_q[29:OFF], {(OFF + 2){1'b0}}};
        arlen   = 8'(LINE_WORDS - 1);
        arsize  = 3'b010;
        arburst = 2'b01;
        rready  = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
            victim_q        <= '0;
            beat_q          <= '0;
            err_q           <= 1'b0;
            flush_pending_q <= 1'b0;
            inst_valid      <= 1'b0;
            inst            <= '0;
            inst_err        <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            if (do_flush) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                    ptr_q[s]   <= '0;
                end
            end
            // A fence seen mid-fetch is held until the fetch has delivered.
            if ((state_q != S_IDLE) && flush_req) begin
                flush_pending_q <= 1'b1;
            end else if (do_flush) begin
                flush_pending_q <= 1'b0;
            end
            case (state_q)
                S_LOOKUP: begin
                    if (hit) begin
                        inst       <= hit_word;
                        inst_valid <= 1'b1;
                        inst_err   <= 1'b0;
                    end else begin
                        victim_q <= victim;
                    end
                end
                S_REFILL: begin
                    if (rvalid) begin
                        beat_q <= beat_cnt_next;
                        err_q  <= err_next;
                        if (commit) begin
                            valid_q[idx][victim_q] <= 1'b1;
                            if (victim_q == ptr_q[idx]) ptr_q[idx] <= ptr_inc;
                        end
                    end
                end
                S_DONE: begin
                    inst       <= cap_q;
                    inst_valid <= 1'b1;
                    inst_err   <= err_q;
                    err_q      <= 1'b0;
                    beat_q     <= '0;
                end
                default: ;
            endcase
        end
    end

    // Storage and request address carry no reset; valid bits gate their use.
    always_ff @(posedge clock) begin
        if ((state_q == S_IDLE) && inst_require) pc_q <= pc[31:2];
        if (beat_fire && beat_in_line) begin
            data_q[victim_q][idx][beat_q[OFF-1:0]] <= rdata;
            if (beat_q[OFF-1:0] == off) cap_q <= rdata;
        end
        if (commit) tag_q[victim_q][idx] <= tag;
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_LOOKUP) begin
            if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
            else     miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_sa.sv
// Scoreboard bench for icache_sa (WAYS=2, SETS=4, LINE_WORDS=4): directed fetches with
// hand-computed instructions, a response monitor and an AR-channel monitor.
module tb_icache_sa;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inst_require = 1'b0;
    logic [31:0] pc = '0;
    logic        fencei = 1'b0;
    logic        ctrl_valid = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_err;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always #5 clock = ~clock;

    icache_sa #(.WAYS(2), .SETS(4), .LINE_WORDS(4)) dut (
        .clock(clock), .reset(reset), .inst_require(inst_require), .pc(pc),
        .fencei(fencei), .ctrl_valid(ctrl_valid), .inst_valid(inst_valid),
        .inst(inst), .inst_err(inst_err), .arvalid(arvalid), .arready(arready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } resp_t;

    resp_t       sb_q[$];
    logic [31:0] ar_q[$];
    resp_t       mon_r;
    logic [31:0] mon_a;
    int pass_cnt   = 0;
    int total_cnt  = 0;
    int delivered  = 0;
    int exp_hits   = 0;
    int exp_misses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Backing memory: the 0x8000_0000 line holds 0x11..0x44, everything else is addr ^ 0x5A5A_0000.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h8000000) begin
            case (a[3:2])
                2'd0: return 32'h11;
                2'd1: return 32'h22;
                2'd2: return 32'h33;
                default: return 32'h44;
            endcase
        end
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(negedge clock) begin
        if (inst_valid) begin
            delivered++;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", {31'b0, inst_valid}, 32'd0);
            end else begin
                mon_r = sb_q.pop_front();
                chk("inst", inst, mon_r.inst);
                chk("inst_err", {31'b0, inst_err}, {31'b0, mon_r.err});
            end
        end
    end

    always @(negedge clock) begin
        #1;
        if (arvalid && arready) begin
            if (ar_q.size() == 0) begin
                chk("ar_unexpected", {31'b0, arvalid}, 32'd0);
            end else begin
                mon_a = ar_q.pop_front();
                chk("araddr", araddr, mon_a);
                chk("arlen", {24'b0, arlen}, 32'd3);
                chk("arsize_burst", {27'b0, arsize, arburst}, {27'b0, 3'b010, 2'b01});
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input bit miss, input logic [31:0] exp_inst,
                         input bit exp_err, input int err_beat, input int fence_beat,
                         input int rst_beat);
        int start;
        int n;
        start = delivered;
        if (miss) begin
            ar_q.push_back({a[31:4], 4'b0});
            exp_misses++;
        end else begin
            exp_hits++;
        end
        if (rst_beat < 0) sb_q.push_back({exp_inst, exp_err});
        @(negedge clock);
        pc = a;
        inst_require = 1'b1;
        @(negedge clock);
        inst_require = 1'b0;
        if (!miss) begin
            @(negedge clock);
            chk("hit_latency", {31'b0, inst_valid}, 32'd1);
        end else begin
            n = 0;
            while (!arvalid && n < 20) begin
                @(negedge clock);
                n++;
            end
            if (!arvalid) begin
                chk("ar_timeout", {31'b0, arvalid}, 32'd1);
            end else begin
                arready = 1'b1;
                @(negedge clock);
                arready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    rvalid     = 1'b1;
                    rdata      = mem_word({a[31:4], 4'b0} + 32'(i * 4));
                    rresp      = (i == err_beat) ? 2'b10 : 2'b00;
                    rlast      = (i == 3);
                    ctrl_valid = (i == fence_beat);
                    fencei     = (i == fence_beat);
                    if (i == rst_beat) begin
                        reset      = 1'b1;
                        exp_hits   = 0;
                        exp_misses = 0;
                    end
                    @(negedge clock);
                    reset      = 1'b0;
                    ctrl_valid = 1'b0;
                    fencei     = 1'b0;
                end
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
            end
        end
        if (rst_beat < 0) begin
            n = 0;
            while (delivered == start && n < 30) begin
                @(posedge clock);
                n++;
            end
            if (delivered == start) chk("resp_timeout", 32'(delivered), 32'(start + 1));
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic fence_idle();
        @(negedge clock);
        ctrl_valid = 1'b1;
        fencei     = 1'b1;
        @(negedge clock);
        ctrl_valid = 1'b0;
        fencei     = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        repeat (3) @(negedge clock);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_err", {31'b0, inst_err}, 32'd0);
        chk("rst_arvalid", {31'b0, arvalid}, 32'd0);
        chk("rst_rready", {31'b0, rready}, 32'd1);
        chk("rst_counters", hit_cnt | miss_cnt, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // addr, miss, inst, err, err_beat, fence_beat, rst_beat
        fetch(32'h8000_0008, 1, 32'h0000_0033, 0, -1, -1, -1);
        fetch(32'h8000_000C, 0, 32'h0000_0044, 0, -1, -1, -1);
        fetch(32'h8000_0040, 1, 32'hDA5A_0040, 0, -1, -1, -1);
        fetch(32'h8000_0080, 1, 32'hDA5A_0080, 0, -1, -1, -1);
        fetch(32'h8000_0040, 0, 32'hDA5A_0040, 0, -1, -1, -1);
        fetch(32'h8000_0000, 1, 32'h0000_0011, 0, -1, -1, -1);
        fetch(32'h8000_0004, 0, 32'h0000_0022, 0, -1, -1, -1);
        fence_idle();
        fetch(32'h8000_0004, 1, 32'h0000_0022, 0, -1, -1, -1);
        fetch(32'h8000_0010, 1, 32'hDA5A_0010, 0, -1,  2, -1);
        fetch(32'h8000_0010, 1, 32'hDA5A_0010, 0, -1, -1, -1);
        fetch(32'h8000_0024, 1, 32'hDA5A_0024, 1,  1, -1, -1);
        fetch(32'h8000_0024, 1, 32'hDA5A_0024, 0, -1, -1, -1);
        fetch(32'h8000_0028, 0, 32'hDA5A_0028, 0, -1, -1, -1);
        fetch(32'h8000_0030, 1, 32'h0000_0000, 0, -1, -1,  2);
        chk("rst_mid_burst_arvalid", {31'b0, arvalid}, 32'd0);
        fetch(32'h8000_0030, 1, 32'hDA5A_0030, 0, -1, -1, -1);
        fetch(32'h8000_0034, 0, 32'hDA5A_0034, 0, -1, -1, -1);
        fetch(32'h8000_0038, 0, 32'hDA5A_0038, 0, -1, -1, -1);
        fetch(32'h8000_003C, 0, 32'hDA5A_003C, 0, -1, -1, -1);

`ifdef ICACHE_PERF_EN
        chk("miss_cnt", miss_cnt, 32'(exp_misses));
        chk("hit_cnt", hit_cnt, 32'(exp_hits));
`else
        chk("miss_cnt", miss_cnt, 32'd0);
        chk("hit_cnt", hit_cnt, 32'd0);
`endif

        @(negedge clock);
        pc           = 32'h8000_0030;
        inst_require = 1'b1;
        ctrl_valid   = 1'b1;
        fencei       = 1'b1;
        @(negedge clock);
        inst_require = 1'b0;
        ctrl_valid   = 1'b0;
        fencei       = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (arvalid || inst_valid) seen = 1'b1;
        end
        chk("flush_wins_over_req", {31'b0, seen}, 32'd0);
        fetch(32'h8000_0034, 1, 32'hDA5A_0034, 0, -1, -1, -1);

        repeat (3) @(negedge clock);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        chk("ar_drain", 32'(ar_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
